// File: rtl/cursor_ctrl.sv
// cursor_ctrl: grid cursor with wrap/clamp edges and hold-to-repeat auto-move
module cursor_ctrl #(
  parameter int MAP_WIDTH = 8,
  parameter int MAP_HEIGHT = 8,
  parameter int WRAP = 1,
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter logic [2:0] GAME_START = 3'd1,
  parameter logic [2:0] GAME_PLAY = 3'd2,
  parameter logic [4:0] BUTTON_LEFT = 5'd1,
  parameter logic [4:0] BUTTON_RIGHT = 5'd2,
  parameter logic [4:0] BUTTON_UP = 5'd4,
  parameter logic [4:0] BUTTON_DOWN = 5'd8,
  localparam int X_W = MAP_WIDTH > 1 ? $clog2(MAP_WIDTH) : 1,
  localparam int Y_W = MAP_HEIGHT > 1 ? $clog2(MAP_HEIGHT) : 1,
  localparam int P_W = MAP_WIDTH * MAP_HEIGHT > 1 ? $clog2(MAP_WIDTH * MAP_HEIGHT) : 1,
  localparam int C_MAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD,
  localparam int C_W = $clog2(C_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2:0]     screen_state_i,
  input  logic [4:0]     button_i,
  output logic [X_W-1:0] x_pos_o,
  output logic [Y_W-1:0] y_pos_o,
  output logic [P_W-1:0] position_o,
  output logic           move_o
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  state_t state, nstate;
  logic [X_W-1:0] x, nx;
  logic [Y_W-1:0] y, ny;
  logic [4:0] dir, ndir;
  logic [C_W-1:0] cnt, ncnt, thr;
  logic step, valid, move;
  localparam logic [X_W-1:0] X_MAX = X_W'(MAP_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(MAP_HEIGHT - 1);
  assign valid = button_i inside {BUTTON_LEFT, BUTTON_RIGHT, BUTTON_UP, BUTTON_DOWN};
  assign thr = state == DELAY ? C_W'(REPEAT_DELAY - 1) : C_W'(REPEAT_PERIOD - 1);
  // candidate coordinate for a step in the currently pressed direction
  assign nx = button_i == BUTTON_LEFT  ? (x != '0    ? x - X_W'(1) : WRAP != 0 ? X_MAX : x) :
              button_i == BUTTON_RIGHT ? (x != X_MAX ? x + X_W'(1) : WRAP != 0 ? '0 : x) : x;
  assign ny = button_i == BUTTON_UP    ? (y != '0    ? y - Y_W'(1) : WRAP != 0 ? Y_MAX : y) :
              button_i == BUTTON_DOWN  ? (y != Y_MAX ? y + Y_W'(1) : WRAP != 0 ? '0 : y) : y;
  always_comb begin
    nstate = state;
    ncnt = cnt;
    ndir = dir;
    step = 1'b0;
    if (screen_state_i != GAME_PLAY) begin
      nstate = IDLE;
      ncnt = '0;
    end else if (state == IDLE) begin
      if (valid) begin
        step = 1'b1;
        ndir = button_i;
        ncnt = '0;
        nstate = DELAY;
      end
    end else if (button_i != dir) begin
      nstate = IDLE;
      ncnt = '0;
    end else if (cnt == thr) begin
      step = 1'b1;
      ncnt = '0;
      nstate = REPEAT;
    end else begin
      ncnt = cnt + C_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      dir <= '0;
      x <= '0;
      y <= '0;
      move <= 1'b0;
    end else if (screen_state_i == GAME_START) begin
      state <= IDLE;
      cnt <= '0;
      dir <= '0;
      x <= '0;
      y <= '0;
      move <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      dir <= ndir;
      move <= step && (nx != x || ny != y);
      if (step) begin
        x <= nx;
        y <= ny;
      end
    end
  assign x_pos_o = x;
  assign y_pos_o = y;
  assign position_o = P_W'(32'(x) + 32'(y) * MAP_WIDTH);
  assign move_o = move;
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: three cursor_ctrl configurations checked against a hold-age reference model
module tb_cursor_ctrl;
  localparam logic [2:0] GS = 3'd1, GP = 3'd2, GO = 3'd5;
  localparam logic [4:0] BL = 5'd1, BR = 5'd2, BU = 5'd4, BD = 5'd8, BN = 5'd0;
  localparam int RD = 4, RP = 2;
  logic clk, rst_n;
  logic [2:0] ss;
  logic [4:0] btn;
  logic [2:0] ax, ay, bx, by, cx;
  logic [1:0] cy;
  logic [5:0] ap, bp;
  logic [3:0] cp;
  logic am, bm, cm;
  int ox[3], oy[3], op[3], om[3];
  int mx[3], my[3], mage[3], mdir[3], mact[3], mmove[3];
  int n_checks = 0, n_err = 0;

  cursor_ctrl #(.MAP_WIDTH(8), .MAP_HEIGHT(8), .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .GAME_START(GS), .GAME_PLAY(GP), .BUTTON_LEFT(BL), .BUTTON_RIGHT(BR), .BUTTON_UP(BU), .BUTTON_DOWN(BD))
    u_a (.clk(clk), .rst_n(rst_n), .screen_state_i(ss), .button_i(btn),
         .x_pos_o(ax), .y_pos_o(ay), .position_o(ap), .move_o(am));
  cursor_ctrl #(.MAP_WIDTH(8), .MAP_HEIGHT(8), .WRAP(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .GAME_START(GS), .GAME_PLAY(GP), .BUTTON_LEFT(BL), .BUTTON_RIGHT(BR), .BUTTON_UP(BU), .BUTTON_DOWN(BD))
    u_b (.clk(clk), .rst_n(rst_n), .screen_state_i(ss), .button_i(btn),
         .x_pos_o(bx), .y_pos_o(by), .position_o(bp), .move_o(bm));
  cursor_ctrl #(.MAP_WIDTH(5), .MAP_HEIGHT(3), .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .GAME_START(GS), .GAME_PLAY(GP), .BUTTON_LEFT(BL), .BUTTON_RIGHT(BR), .BUTTON_UP(BU), .BUTTON_DOWN(BD))
    u_c (.clk(clk), .rst_n(rst_n), .screen_state_i(ss), .button_i(btn),
         .x_pos_o(cx), .y_pos_o(cy), .position_o(cp), .move_o(cm));

  always #5 clk = ~clk;

  always_comb begin
    ox[0] = int'(ax); oy[0] = int'(ay); op[0] = int'(ap); om[0] = int'(am);
    ox[1] = int'(bx); oy[1] = int'(by); op[1] = int'(bp); om[1] = int'(bm);
    ox[2] = int'(cx); oy[2] = int'(cy); op[2] = int'(cp); om[2] = int'(cm);
  end

  function automatic int pw(int i); return i == 2 ? 5 : 8; endfunction
  function automatic int ph(int i); return i == 2 ? 3 : 8; endfunction
  function automatic int pwrap(int i); return i == 1 ? 0 : 1; endfunction

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = 0; my[i] = 0; mact[i] = 0; mmove[i] = 0; mage[i] = 0; mdir[i] = 0;
    end
  endtask

  task automatic model_move(int i, int b);
    int nx, ny;
    nx = mx[i]; ny = my[i];
    if (b == BL) nx = mx[i] - 1;
    if (b == BR) nx = mx[i] + 1;
    if (b == BU) ny = my[i] - 1;
    if (b == BD) ny = my[i] + 1;
    if (nx < 0) nx = pwrap(i) != 0 ? pw(i) - 1 : 0;
    if (nx >= pw(i)) nx = pwrap(i) != 0 ? 0 : pw(i) - 1;
    if (ny < 0) ny = pwrap(i) != 0 ? ph(i) - 1 : 0;
    if (ny >= ph(i)) ny = pwrap(i) != 0 ? 0 : ph(i) - 1;
    mmove[i] = (nx != mx[i] || ny != my[i]) ? 1 : 0;
    mx[i] = nx; my[i] = ny;
  endtask

  // steps fall at hold age 0, RD, RD+RP, RD+2RP, ...
  task automatic model_step();
    int b;
    b = int'(btn);
    for (int i = 0; i < 3; i++) begin
      mmove[i] = 0;
      if (ss == GS) begin
        mx[i] = 0; my[i] = 0; mact[i] = 0;
      end else if (ss != GP) begin
        mact[i] = 0;
      end else if (mact[i] == 0) begin
        if (b == BL || b == BR || b == BU || b == BD) begin
          model_move(i, b); mact[i] = 1; mdir[i] = b; mage[i] = 0;
        end
      end else if (b != mdir[i]) begin
        mact[i] = 0;
      end else begin
        mage[i]++;
        if (mage[i] == RD || (mage[i] > RD && (mage[i] - RD) % RP == 0)) model_move(i, b);
      end
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_d%0d_x", tag, i), ox[i], mx[i]);
      chk($sformatf("%s_d%0d_y", tag, i), oy[i], my[i]);
      chk($sformatf("%s_d%0d_pos", tag, i), op[i], mx[i] + my[i] * pw(i));
      chk($sformatf("%s_d%0d_move", tag, i), om[i], mmove[i]);
    end
  endtask

  task automatic cyc(string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    logic [2:0] s;
    logic [4:0] b;
    int ex, ey, ep, em;
  } vec_t;
  vec_t tbl[13];

  initial begin
    int rep_x[9];
    tbl[0]  = '{GS, BN, 0, 0, 0, 0};
    tbl[1]  = '{GP, BL, 7, 0, 7, 1};
    tbl[2]  = '{GP, BN, 7, 0, 7, 0};
    tbl[3]  = '{GP, BU, 7, 7, 63, 1};
    tbl[4]  = '{GP, BN, 7, 7, 63, 0};
    tbl[5]  = '{GP, BR, 0, 7, 56, 1};
    tbl[6]  = '{GP, BR, 0, 7, 56, 0};
    tbl[7]  = '{GP, BD, 0, 7, 56, 0};
    tbl[8]  = '{GP, BD, 0, 0, 0, 1};
    tbl[9]  = '{GP, BN, 0, 0, 0, 0};
    tbl[10] = '{GO, BL, 0, 0, 0, 0};
    tbl[11] = '{GP, BL, 7, 0, 7, 1};
    tbl[12] = '{GS, BN, 0, 0, 0, 0};
    rep_x = '{1, 1, 1, 1, 2, 2, 3, 3, 4};
    clk = 0; rst_n = 0; ss = GP; btn = BN;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 13; k++) begin
      ss = tbl[k].s; btn = tbl[k].b;
      cyc("tbl");
      chk($sformatf("tbl%0d_x", k), ox[0], tbl[k].ex);
      chk($sformatf("tbl%0d_y", k), oy[0], tbl[k].ey);
      chk($sformatf("tbl%0d_pos", k), op[0], tbl[k].ep);
      chk($sformatf("tbl%0d_move", k), om[0], tbl[k].em);
    end
    ss = GP; btn = BL; cyc("clamp");
    chk("clamp_left_x", ox[1], 0); chk("clamp_left_move", om[1], 0);
    btn = BN; cyc("clamp");
    btn = BR; cyc("clamp");
    chk("clamp_right_x", ox[1], 1); chk("clamp_right_move", om[1], 1);
    btn = BN; cyc("clamp");
    ss = GS; cyc("rep");
    ss = GP; btn = BR;
    for (int k = 0; k < 9; k++) begin
      cyc("rep");
      chk($sformatf("rep%0d_x", k), ox[0], rep_x[k]);
    end
    btn = BN;
    for (int k = 0; k < 4; k++) begin
      cyc("rel");
      chk("rel_x", ox[0], 4); chk("rel_move", om[0], 0);
    end
    ss = GS; cyc("nsq");
    ss = GP; btn = BL; cyc("nsq");
    btn = BN; cyc("nsq");
    btn = BU; cyc("nsq");
    chk("nsq_at_x", ox[2], 4); chk("nsq_at_y", oy[2], 2); chk("nsq_at_pos", op[2], 14);
    btn = BN; cyc("nsq");
    btn = BD; cyc("nsq");
    chk("nsq_down_y", oy[2], 0); chk("nsq_down_pos", op[2], 4); chk("nsq_down_move", om[2], 1);
    ss = GO; btn = BL;
    for (int k = 0; k < 10; k++) begin
      cyc("gate");
      chk("gate_x", ox[2], 4); chk("gate_move", om[2], 0);
    end
    ss = GS; btn = BN; cyc("chg");
    ss = GP; btn = BR; cyc("chg"); cyc("chg");
    btn = BD; cyc("chg");
    chk("chg_idle_y", oy[0], 0); chk("chg_idle_move", om[0], 0);
    cyc("chg");
    chk("chg_down_y", oy[0], 1); chk("chg_down_x", ox[0], 1); chk("chg_down_move", om[0], 1);
    for (int k = 0; k < 3; k++) begin
      cyc("chg");
      chk("chg_no_right", ox[0], 1);
    end
    btn = BR; cyc("mid"); cyc("mid"); cyc("mid");
    rst_n = 0; btn = BN;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1;
    cyc("post_rst"); cyc("post_rst");
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = $urandom_range(0, 99);
      ss = r < 3 ? GS : r < 8 ? GO : GP;
      if ($urandom_range(0, 9) >= 8) begin
        case ($urandom_range(0, 5))
          0: btn = BN;
          1: btn = BL;
          2: btn = BR;
          3: btn = BU;
          4: btn = BD;
          default: btn = 5'($urandom);
        endcase
      end
      cyc("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Parametrised cursor controller for the minesweeper playfield. It turns direction-button codes into a selected-cell coordinate on a MAP_WIDTH × MAP_HEIGHT grid, with wrap or clamp at the edges and hold-to-repeat auto-move. It sits between the button front-end and the game core and rendering logic, and is active only in the `GAME_PLAY` screen state. It is the drop-in generalisation of the fixed 8×8 single-step cursor mover.

## Interface
Parameters:
- MAP_WIDTH, 8: grid columns, ≥1.
- MAP_HEIGHT, 8: grid rows, ≥1.
- WRAP, 1: edge mode. 1 = wrap to the opposite edge; 0 = clamp at the edge.
- REPEAT_DELAY, 12_500_000: hold cycles from the first step to the first auto-repeat step, ≥1.
- REPEAT_PERIOD, 5_000_000: cycles between later auto-repeat steps, ≥1.
- Derived (localparam): X_W = max(1, clog2(MAP_WIDTH)), Y_W = max(1, clog2(MAP_HEIGHT)), P_W = max(1, clog2(MAP_WIDTH·MAP_HEIGHT)), C_W = clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- screen_state_i  in  3  screen state (`GAME_START`, `GAME_PLAY`, others from parameter.v).
- button_i  in  5  button code. `BUTTON_LEFT`, `BUTTON_RIGHT`, `BUTTON_UP` and `BUTTON_DOWN` are directions; any other value means no direction.
- x_pos_o  out  X_W  cursor column, 0..MAP_WIDTH-1.
- y_pos_o  out  Y_W  cursor row, 0..MAP_HEIGHT-1.
- position_o  out  P_W  linear index, x + y·MAP_WIDTH.
- move_o  out  1  one-cycle pulse in the cycle after the cursor changes.

## Operation
- Registered state: cursor x and y, FSM state, latched direction `dir`, and repeat counter `cnt`. All outputs come directly from registers or are a combinational function of the cursor registers.
- FSM states:
  - IDLE: no direction latched.
  - DELAY: counting REPEAT_DELAY.
  - REPEAT: counting REPEAT_PERIOD.
- Priority each clock: `GAME_START` > not `GAME_PLAY` > FSM.
  - `GAME_START`: x=y=0, state=IDLE, cnt=0, move_o=0.
  - Any other non-PLAY state: cursor holds, state=IDLE, cnt=0, no steps.
- IDLE: on a valid direction, issue a step in that direction, latch `dir`, set cnt=0, go to DELAY.
- DELAY: if button_i ≠ `dir` (release or change), go to IDLE with no step. Else if cnt == REPEAT_DELAY-1, issue a step, set cnt=0, go to REPEAT. Else cnt++.
- REPEAT: same as DELAY but the threshold is REPEAT_PERIOD-1, and the state stays REPEAT.
- Changing direction while held costs one cycle: DELAY/REPEAT → IDLE, and the new code is accepted the next cycle.
- Step arithmetic:
  - LEFT: x-1. RIGHT: x+1. UP: y-1. DOWN: y+1.
  - The other axis is unchanged.
  - At an edge: WRAP=1 goes to the opposite edge (0 ↔ MAP_WIDTH-1 or MAP_HEIGHT-1). WRAP=0 holds the coordinate.
- move_o: asserted for exactly one cycle only when (x,y) actually changes. A clamped step, or a wrap with dimension 1, gives no pulse.
- position_o: computed at P_W width. The x + y·MAP_WIDTH product and sum must not truncate before the final width.

## Timing
- Reset (async assert, sync release): x_pos_o=0, y_pos_o=0, position_o=0, move_o=0, state IDLE, cnt=0, dir=none.
- First-press latency: button sampled at edge N; new x/y/position and move_o=1 are visible after edge N. move_o drops after edge N+1.
- Continuous hold starting at edge N: steps occur at N, N+REPEAT_DELAY, then every REPEAT_PERIOD cycles.
- Release at edge M: no step at or after M. Pressing again at M+1 gives an immediate step.
- Reset asserted mid-hold: all registers clear at once, with no step or pulse on release.
- Leaving `GAME_PLAY` mid-hold: the counter is abandoned. Returning to PLAY with the button still held gives an immediate step, because IDLE accepts the held code.

## Test plan
- Reset and start: assert rst_n=0 mid-operation → all outputs 0. Drive `GAME_START` with cursor at (3,5) → (0,0), position 0, no move_o.
- Wrap, 8×8, WRAP=1: at (0,0) press LEFT 1 cycle → (7,0), position 7, move_o 1 cycle. Press UP → (7,7), position 63.
- Clamp, 8×8, WRAP=0: at (0,0) press LEFT → stays (0,0), move_o stays 0. Press RIGHT → (1,0), move_o pulses.
- Auto-repeat, REPEAT_DELAY=4, REPEAT_PERIOD=2: hold RIGHT for 9 cycles from (0,0) → steps at cycles 0, 4, 6, 8 → (4,0). Release → no further steps.
- Non-square with gating, 5×3: from (4,2) press DOWN → (4,0), position 4. With screen_state ≠ PLAY, hold LEFT for 10 cycles → no change, move_o 0.
- Direction change: hold RIGHT, switch to DOWN mid-DELAY → one idle cycle, then DOWN step. No RIGHT repeat fires.
